imem_loader: RTL and testbench

Boot-time program loader sitting directly upstream of `cpu`. It accepts 32-bit instruction words over a valid/ready stream and writes them little-endian, one byte per cycle, into the byte-addressed instruction memory (`cpu.instr_mem.imem`). It holds the CPU in reset while loading, then releases it. This replaces per-test hierarchical preloading of `imem` with a synthesizable path.

---
 rtl/imem_loader.sv | 141 ++++++++++++++
 tb/tb_imem_loader.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot loader: streams 32-bit words into byte-wide instruction memory (little-endian),
// holding the CPU in reset until the last word lands plus a short settling window.
module imem_loader #(
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned BASE     = 0,
  parameter int unsigned RST_HOLD = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [31:0]       s_data,
  input  logic              s_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-2:0] word_count
);

  // state | meaning
  // IDLE  | after reset, CPU held, waiting for start
  // RECV  | ready for the next word
  // WR    | writing the latched word, one byte per cycle
  // HOLD  | last word written, CPU reset still held for RST_HOLD cycles
  // RUN   | CPU released and running the loaded program
  // ERR   | byte pointer wrapped before the last word; waits for start
  typedef enum logic [2:0] {IDLE, RECV, WR, HOLD, RUN, ERR} state_t;

  localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(BASE);
  localparam logic [3:0]        HOLD_INIT = 4'(RST_HOLD - 1);

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   ptr, ptr_nx;
  logic [1:0]          idx, idx_nx;
  logic [31:0]         word_q, word_nx;
  logic                last_q, last_nx;
  logic [3:0]          hold_cnt, hold_nx;
  logic [ADDR_W-2:0]   wc_nx;
  logic                we_nx;
  logic [ADDR_W-1:0]   addr_nx;
  logic [7:0]          wdata_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= BASE_A;
      idx        <= '0;
      word_q     <= '0;
      last_q     <= 1'b0;
      hold_cnt   <= '0;
      word_count <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      s_ready    <= 1'b0;
      cpu_rst    <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= state_nx;
      ptr        <= ptr_nx;
      idx        <= idx_nx;
      word_q     <= word_nx;
      last_q     <= last_nx;
      hold_cnt   <= hold_nx;
      word_count <= wc_nx;
      mem_we     <= we_nx;
      mem_addr   <= addr_nx;
      mem_wdata  <= wdata_nx;
      s_ready    <= (state_nx == RECV);
      cpu_rst    <= (state_nx != RUN);
      done       <= (state_nx == RUN);
      error      <= (state_nx == ERR);
    end
  end

  // idx names the byte to issue at the coming edge; idx==0 inside WR means byte 3 is on the bus.
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    idx_nx   = idx;
    word_nx  = word_q;
    last_nx  = last_q;
    hold_nx  = hold_cnt;
    wc_nx    = word_count;
    we_nx    = 1'b0;
    addr_nx  = mem_addr;
    wdata_nx = mem_wdata;
    case (state)
      IDLE, RUN, ERR: begin
        if (start) begin
          state_nx = RECV;
          ptr_nx   = BASE_A;
          wc_nx    = '0;
        end
      end
      RECV: begin
        if (s_valid && s_ready) begin
          state_nx = WR;
          word_nx  = s_data;
          last_nx  = s_last;
          idx_nx   = 2'd1;
          we_nx    = 1'b1;
          addr_nx  = ptr;
          wdata_nx = s_data[7:0];
          ptr_nx   = ptr + ADDR_W'(1);
        end
      end
      WR: begin
        if (idx != 2'd0) begin
          we_nx    = 1'b1;
          addr_nx  = ptr;
          wdata_nx = word_q[{idx, 3'b000} +: 8];
          ptr_nx   = ptr + ADDR_W'(1);
          idx_nx   = idx + 2'd1;
        end else begin
          if (word_count != '1) wc_nx = word_count + (ADDR_W-1)'(1);
          // Words are aligned, so a wrap can only come from the byte-3 increment.
          if (last_q) begin
            state_nx = HOLD;
            hold_nx  = HOLD_INIT;
          end else if (ptr == '0) begin
            state_nx = ERR;
          end else begin
            state_nx = RECV;
          end
        end
      end
      HOLD: begin
        if (hold_cnt == '0) state_nx = RUN;
        else                hold_nx  = hold_cnt - 4'd1;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (16-byte memory): word streaming, hold timing,
// reload, exact fill, overflow, and asynchronous reset during a word write.
module tb_imem_loader;
  logic        clk, rst, start, s_valid, s_ready, s_last;
  logic [31:0] s_data;
  logic        mem_we, cpu_rst, done, error;
  logic [3:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [2:0]  word_count;
  logic [7:0]  tb_mem [16];
  int total = 0, bad = 0;

  imem_loader #(.ADDR_W(4), .BASE(0), .RST_HOLD(2)) dut (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_rst(cpu_rst), .done(done), .error(error),
    .word_count(word_count));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we === 1'b1) tb_mem[mem_addr] <= mem_wdata;

  typedef struct {
    logic        sess;
    logic [31:0] d;
    logic        l;
    int          gap;
    logic [3:0]  a0;
    logic [7:0]  b0, b1, b2, b3;
    logic [2:0]  wc;
    logic        poke;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, s_ready, 0);
    chk({tag, "_we"}, mem_we, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_cpu_rst"}, cpu_rst, 1);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_wc"}, word_count, 0);
  endtask

  // Called at a negedge; returns at the negedge of cycle N+5 after the handshake.
  task automatic send_word(input logic [31:0] d, input logic l, input logic [3:0] a0,
                           input logic [7:0] b0, b1, b2, b3, input logic poke);
    logic [7:0] eb [4];
    logic [3:0] ea;
    int n;
    eb[0] = b0; eb[1] = b1; eb[2] = b2; eb[3] = b3;
    s_data = d; s_last = l; s_valid = 1'b1; n = 0;
    while (s_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      total++; bad++;
      $display("FAIL handshake_timeout: s_ready=%b expected 1", s_ready);
      s_valid = 1'b0;
      return;
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) begin s_valid = 1'b0; s_data = ~d; s_last = 1'b0; end
      start = poke && (k == 1);
      ea = a0 + 4'(k);
      chk("byte_we", mem_we, 1);
      chk("byte_addr", mem_addr, ea);
      chk("byte_data", mem_wdata, eb[k]);
      chk("ready_low", s_ready, 0);
    end
    @(negedge clk); start = 1'b0;
    chk("we_off", mem_we, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b1, 32'hDEADBEEF, 1'b0, 0, 4'd0,  8'hEF, 8'hBE, 8'hAD, 8'hDE, 3'd1, 1'b0};
    tbl[1] = '{1'b0, 32'h12345678, 1'b0, 0, 4'd4,  8'h78, 8'h56, 8'h34, 8'h12, 3'd2, 1'b1};
    tbl[2] = '{1'b0, 32'hA5C30F81, 1'b1, 3, 4'd8,  8'h81, 8'h0F, 8'hC3, 8'hA5, 3'd3, 1'b0};
    tbl[3] = '{1'b1, 32'h00000013, 1'b0, 1, 4'd0,  8'h13, 8'h00, 8'h00, 8'h00, 3'd1, 1'b0};
    tbl[4] = '{1'b0, 32'h00100113, 1'b0, 0, 4'd4,  8'h13, 8'h01, 8'h10, 8'h00, 3'd2, 1'b0};
    tbl[5] = '{1'b0, 32'h00208193, 1'b0, 2, 4'd8,  8'h93, 8'h81, 8'h20, 8'h00, 3'd3, 1'b0};
    tbl[6] = '{1'b0, 32'hFFFFFFFF, 1'b1, 0, 4'd12, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 3'd4, 1'b0};

    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;

    // single word from IDLE
    pulse_start();
    chk("idle_start_ready", s_ready, 1);
    send_word(32'h00500093, 1'b1, 4'd0, 8'h93, 8'h00, 8'h50, 8'h00, 1'b0);
    chk("hold1_cpu_rst", cpu_rst, 1);
    chk("hold1_done", done, 0);
    chk("single_wc", word_count, 1);
    @(negedge clk);
    chk("hold2_cpu_rst", cpu_rst, 1);
    @(negedge clk);
    chk("run_cpu_rst", cpu_rst, 0);
    chk("run_done", done, 1);

    // reload from RUN, then multi-word sessions including an exact fill
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].sess) begin
        pulse_start();
        chk("sess_cpu_rst", cpu_rst, 1);
        chk("sess_done", done, 0);
        chk("sess_ready", s_ready, 1);
        chk("sess_wc", word_count, 0);
      end
      repeat (tbl[i].gap) begin @(negedge clk); chk("gap_ready", s_ready, 1); end
      send_word(tbl[i].d, tbl[i].l, tbl[i].a0, tbl[i].b0, tbl[i].b1, tbl[i].b2, tbl[i].b3,
                tbl[i].poke);
      chk("vec_wc", word_count, tbl[i].wc);
      chk("vec_ready_after", s_ready, !tbl[i].l);
      chk("vec_error", error, 0);
      if (tbl[i].l) begin
        repeat (2) @(negedge clk);
        chk("vec_done", done, 1);
        chk("vec_cpu_rst", cpu_rst, 0);
        chk("vec_error_run", error, 0);
      end
    end

    // overflow: four words without last fill all 16 bytes and wrap
    pulse_start();
    for (int w = 0; w < 4; w++) begin
      send_word({8'(4*w+4), 8'(4*w+3), 8'(4*w+2), 8'(4*w+1)}, 1'b0, 4'(4*w),
                8'(4*w+1), 8'(4*w+2), 8'(4*w+3), 8'(4*w+4), 1'b0);
    end
    chk("ovf_error", error, 1);
    chk("ovf_cpu_rst", cpu_rst, 1);
    chk("ovf_ready", s_ready, 0);
    chk("ovf_done", done, 0);
    chk("ovf_wc", word_count, 4);
    s_data = 32'h0BADF00D; s_valid = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("err_no_accept_we", mem_we, 0);
      chk("err_no_accept_ready", s_ready, 0);
    end
    chk("err_sticky", error, 1);
    s_valid = 1'b0;
    pulse_start();
    chk("err_clear", error, 0);
    chk("err_restart_ready", s_ready, 1);
    chk("err_restart_cpu_rst", cpu_rst, 1);

    // asynchronous reset while byte 2 of a word is on the bus
    s_data = 32'hCAFEBABE; s_last = 1'b0; s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    chk("rwr_b0_addr", mem_addr, 0);
    chk("rwr_b0_data", mem_wdata, 8'hBE);
    @(negedge clk);
    chk("rwr_b1_data", mem_wdata, 8'hBA);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_reset_vals("rst_mid_wr");
    @(negedge clk);
    rst = 1'b0;
    chk("mem_kept_b0", tb_mem[0], 8'hBE);
    chk("mem_kept_b1", tb_mem[1], 8'hBA);
    chk("mem_no_b2", tb_mem[2], 8'h03);
    @(negedge clk);
    chk("post_rst_idle_ready", s_ready, 0);
    chk("post_rst_we", mem_we, 0);
    pulse_start();
    chk("post_rst_start_ready", s_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
